div_sigcalc_ctrl: RTL
=====================

Name: div_sigcalc_ctrl

Overview:
- Flow controller for the pipelined radix-4 significand divider core (`div_sigcalc`, PIPE_STAGES in {0..3}).
- Owns the core's global `enable`. Tracks a valid bit and sideband word per core pipeline register. Captures core results into a 2-entry output skid buffer.
- Presents valid/ready handshakes on both sides, so the FP divide top level can apply backpressure without a combinational path from out_ready to in_ready or enable.

Parameters:
- SIG_WIDTH, 23, significand width minus one (core operand width is SIG_WIDTH+1).
- PIPE_STAGES, 0, number of core pipeline registers L; legal 0..3; must match the core instance.
- SIDE_W, 16, width of sideband carried alongside each operation (sign, exponent, tag).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous kill of all in-flight and buffered ops
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts operands this cycle
- in_side  in  SIDE_W  sideband for the operation
- core_enable  out  1  drives the core's enable input
- core_quotient  in  SIG_WIDTH+1  from core
- core_guard, core_round, core_sticky, core_count  in  1 each  from core
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_result  out  SIG_WIDTH+5  {quotient, guard, round, sticky, count}
- out_side  out  SIDE_W  sideband of the result
- busy  out  1  any op in flight or buffered

Behaviour:
- Reset/polarity: clk and rst only; rst is asynchronous, active-high.
- Reset values: all stage valid bits 0, skid count 0, out_valid 0, out_result 0, out_side 0, busy 0. core_enable evaluates to 1 after reset.
- Stage valids: vld[0..L-1] and side[0..L-1] shift register.
  - Entry: vld[0] <= in_valid && in_ready.
  - Shift only when core_enable=1; hold otherwise.
- last_valid: vld[L-1] for L>0; in_valid for L=0.
- Result capture: push = last_valid && core_enable. Result fields and the sideband (side[L-1], or in_side for L=0) are written to the skid tail.
- Skid buffer: 2 entries, count 0..2. pop = out_valid && out_ready. Push and pop in the same cycle leaves count unchanged.
- Enable: core_enable = (count < 2) || !last_valid.
  - Depends only on registered state, plus in_valid when L=0.
  - A pop in the same cycle does not raise core_enable. This is deliberate: it keeps the path from out_ready registered-free.
- in_ready = core_enable && !flush.
- Outputs: out_valid = (count != 0). out_result and out_side show the head entry and are held stable while out_valid && !out_ready.
- Latency: accept to out_valid is L+1 cycles when unstalled.
- Throughput: one op per cycle when out_ready stays high (count steady at 1).
- Order: strictly in order; no reordering or bubble collapsing. A global enable moves bubbles with data.
- busy = |vld || (count != 0).
- Flush (takes priority over push, pop and entry in its cycle):
  - Next cycle: all vld 0 and count 0.
  - Skid data contents are don't-care, but out_result is driven 0 when count is 0.
  - Core datapath registers are not cleared; their contents are ignored because vld is 0.
- Reset mid-operation: all state clears immediately; no result is emitted for ops in flight.
- Boundary conditions:
  - count==2 with last_valid=1: core stalls; the last-stage op waits in the core.
  - count==2 with last_valid=0: the core keeps shifting to fill bubbles.
  - L=0: the core is combinational, so the result is captured the cycle the operands are accepted.
- Sizing: one generate branch per PIPE_STAGES value for the vld and side arrays.

Test Plan:
- PIPE_STAGES=2, out_ready=1, ops A,B,C on consecutive cycles -> out_valid rises 3 cycles after A accepted; A,B,C are emitted on consecutive cycles with matching out_side; core_enable stays 1.
- PIPE_STAGES=3, out_ready=0, 6 back-to-back ops:
  - count reaches 2 and core_enable drops.
  - in_ready=0 with the third op held at vld[2].
  - Raise out_ready -> all 6 emitted in order, no loss or duplication.
- PIPE_STAGES=1, out_ready toggling 1,0,1,0 with a continuous input stream -> out_result is stable whenever out_valid && !out_ready, and order is preserved.
- PIPE_STAGES=2, two ops in flight plus one buffered, flush=1 for one cycle -> next cycle busy=0, out_valid=0; an op arriving during the flush cycle is rejected (in_ready=0).
- PIPE_STAGES=0, in_valid=1 with x=1.5, d=1.0 (SIG_WIDTH=23) -> out_valid after 1 cycle with the core's quotient of 1.5 captured unmodified; in_valid with count=2 -> in_ready=0.
- Any config, assert rst asynchronously mid-stream between clock edges -> all outputs reach their reset values immediately; after release, the first new op completes with latency L+1.

Source files
------------

// File: rtl/div_sigcalc_ctrl.sv
// Flow controller for the pipelined radix-4 significand divider core.
// Owns the core's global enable, tracks one valid bit and sideband word per
// core pipeline register, and captures core results into a 2-entry skid
// buffer. out_ready only ever affects registered state, so there is no
// combinational path from out_ready to in_ready or core_enable.
module div_sigcalc_ctrl #(
  parameter int SIG_WIDTH   = 23,
  parameter int PIPE_STAGES = 0,
  parameter int SIDE_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIDE_W-1:0]    in_side,
  output logic                 core_enable,
  input  logic [SIG_WIDTH:0]   core_quotient,
  input  logic                 core_guard,
  input  logic                 core_round,
  input  logic                 core_sticky,
  input  logic                 core_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIG_WIDTH+4:0] out_result,
  output logic [SIDE_W-1:0]    out_side,
  output logic                 busy
);

  localparam int RES_W = SIG_WIDTH + 5;
  localparam int L     = PIPE_STAGES;

  logic              last_valid;
  logic [SIDE_W-1:0] last_side;
  logic              any_vld;
  logic              push, pop;

  logic [1:0]        cnt;
  logic              rd_ptr, wr_ptr;
  logic [RES_W-1:0]  res_q  [2];
  logic [SIDE_W-1:0] side_q [2];
  logic [RES_W-1:0]  core_res;

  assign core_res = {core_quotient, core_guard, core_round, core_sticky, core_count};

  // Stall only when the skid is full and the last stage actually holds an op;
  // a pop this cycle deliberately does not reopen the core.
  assign core_enable = (cnt != 2'd2) || !last_valid;
  assign in_ready    = core_enable && !flush;
  assign push        = last_valid && core_enable;
  assign pop         = out_valid && out_ready;

  generate
    if (L == 0) begin : g_comb
      // Combinational core: the result belongs to the operands presented now.
      assign last_valid = in_valid;
      assign last_side  = in_side;
      assign any_vld    = 1'b0;
    end else begin : g_pipe
      logic [L-1:0]             vld;
      logic [L-1:0][SIDE_W-1:0] side;

      // Valid/sideband shadow of the core pipeline; moves only with the core.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld  <= '0;
          side <= '0;
        end else if (flush) begin
          vld <= '0;
        end else if (core_enable) begin
          vld[0]  <= in_valid && in_ready;
          side[0] <= in_side;
          for (int i = 1; i < L; i++) begin
            vld[i]  <= vld[i-1];
            side[i] <= side[i-1];
          end
        end
      end

      assign last_valid = vld[L-1];
      assign last_side  = side[L-1];
      assign any_vld    = |vld;
    end
  endgenerate

  // Skid occupancy and pointers; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  // Skid data: contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      res_q[wr_ptr]  <= core_res;
      side_q[wr_ptr] <= last_side;
    end
  end

  assign out_valid  = (cnt != 2'd0);
  assign out_result = out_valid ? res_q[rd_ptr]  : '0;
  assign out_side   = out_valid ? side_q[rd_ptr] : '0;
  assign busy       = any_vld || out_valid;

endmodule
